// File: rtl/display_pkg.sv
// display_pkg: shared types and helpers for the seven-segment scan controller.
//   NIBBLE_W     - bits per displayed digit (shared decoder input width)
//   MAX_DIGITS   - widest digit bank the controller supports
//   scan_state_t - per-slot phase: BLANK (all digits off) / SHOW (one digit lit)
//   onehot_digit - digit index to one-hot enable, MAX_DIGITS wide
package display_pkg;
  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_t;

  function automatic logic [MAX_DIGITS-1:0] onehot_digit(input logic [2:0] idx);
    onehot_digit      = '0;
    onehot_digit[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/scan_slot_timer.sv
// scan_slot_timer: owns the slot counter (0..SCAN_DIV-1) and the digit index.
// Ports:
//   i_clk, i_rst      - clock, async active-high reset
//   o_idx_nxt         - digit index that will be current after the next edge
//   o_slot_start      - current cycle is the first of a slot (counter == 0)
//   o_slot_end        - current cycle is the last of a slot
//   o_show_nxt        - the cycle after the next edge lies in the SHOW window
//   o_frame_end       - current cycle is the last cycle of the last digit slot
// Strobes ending in _nxt look one edge ahead so the top can register its
// outputs and still have them line up with the counter value.
module scan_slot_timer #(
  parameter  int NUM_DIGITS   = 4,
  parameter  int SCAN_DIV     = 50000,
  parameter  int BLANK_CYCLES = 64,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(SCAN_DIV)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [IW-1:0] o_idx_nxt,
  output logic          o_slot_start,
  output logic          o_slot_end,
  output logic          o_show_nxt,
  output logic          o_frame_end
);

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_last_digit;

  assign o_slot_start = (r_cnt == '0);
  assign o_slot_end   = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_last_digit = (r_idx == IW'(NUM_DIGITS - 1));
  assign o_frame_end  = o_slot_end & w_last_digit;

  assign w_cnt_nxt = o_slot_end ? '0 : (r_cnt + CW'(1));
  assign o_idx_nxt = !o_slot_end  ? r_idx :
                     w_last_digit ? '0    : (r_idx + IW'(1));
  assign o_show_nxt = (w_cnt_nxt >= CW'(BLANK_CYCLES));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= o_idx_nxt;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS
// common-enable seven-segment digits sharing one nibble decoder.
// Ports:
//   i_clk, i_rst       - clock, async active-high reset
//   i_load_valid       - new display value offered
//   i_load_data        - packed value, digit k in bits [4k+3:4k]
//   o_load_ready       - a new value can be accepted (no value pending)
//   i_suppress_lz      - blank leading zero digits (sampled per slot)
//   o_nibble           - current digit value to the shared decoder
//   o_digit_en         - one-hot digit enable, zero during blanking
//   o_frame_end style pulse on o_frame_tick after each full scan frame
// A value accepted through the handshake waits in a shadow register and is
// only copied to the display register at a frame boundary, so one frame
// never mixes two values.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_load_valid,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_load_data,
  output logic                           o_load_ready,
  input  logic                           i_suppress_lz,
  output logic [NIBBLE_W-1:0]            o_nibble,
  output logic [NUM_DIGITS-1:0]          o_digit_en,
  output logic                           o_frame_tick
);

  localparam int DW = NIBBLE_W * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [IW-1:0]         w_idx_nxt;
  logic                  w_slot_start, w_slot_end, w_show_nxt, w_frame_end;
  logic                  w_accept, w_commit, w_pending_nxt, w_sup;
  logic [DW-1:0]         w_disp_nxt;
  logic [NUM_DIGITS-1:0] w_supp, w_en_show;
  logic [NIBBLE_W-1:0]   w_nib_nxt;

  scan_state_t           r_state;
  logic [DW-1:0]         r_disp, r_shadow;
  logic                  r_pending, r_sup;
  logic [NIBBLE_W-1:0]   r_nibble;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic                  r_frame_tick, r_load_ready;

  scan_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_idx_nxt   (w_idx_nxt),
    .o_slot_start(w_slot_start),
    .o_slot_end  (w_slot_end),
    .o_show_nxt  (w_show_nxt),
    .o_frame_end (w_frame_end)
  );

  // Handshake: ready is ~pending, so accept and commit never coincide.
  assign w_accept      = i_load_valid & r_load_ready;
  assign w_commit      = w_frame_end & r_pending;
  assign w_pending_nxt = w_accept | (r_pending & ~w_commit);
  assign w_disp_nxt    = w_commit ? r_shadow : r_disp;

  // Suppress-LZ is latched during the counter==0 cycle; using the live input
  // in that cycle keeps BLANK_CYCLES==1 correct.
  assign w_sup = w_slot_start ? i_suppress_lz : r_sup;

  // Digit k (k>0) is a leading zero when it and every digit above it are 0.
  assign w_supp[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
    assign w_supp[k] = (w_disp_nxt[DW-1:NIBBLE_W*k] == '0);
  end

  assign w_en_show = (w_sup && w_supp[w_idx_nxt]) ? '0
                   : NUM_DIGITS'(onehot_digit(3'(w_idx_nxt)));
  assign w_nib_nxt = w_disp_nxt[w_idx_nxt*NIBBLE_W +: NIBBLE_W];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= BLANK;
      r_disp       <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_sup        <= 1'b0;
      r_nibble     <= '0;
      r_digit_en   <= '0;
      r_frame_tick <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_frame_tick <= w_frame_end;
      r_sup        <= w_sup;
      r_disp       <= w_disp_nxt;
      r_pending    <= w_pending_nxt;
      r_load_ready <= ~w_pending_nxt;
      if (w_accept) r_shadow <= i_load_data;
      case (r_state)
        // Nibble was set on entry to BLANK; the digit is lit once the
        // decoder has had the whole blanking guard to settle.
        BLANK: if (w_show_nxt) begin
          r_state    <= SHOW;
          r_digit_en <= w_en_show;
        end
        // Slot end always falls in SHOW since SCAN_DIV > BLANK_CYCLES.
        SHOW: if (w_slot_end) begin
          r_state    <= BLANK;
          r_digit_en <= '0;
          r_nibble   <= w_nib_nxt;
        end
        default: r_state <= BLANK;
      endcase
    end
  end

  assign o_nibble     = r_nibble;
  assign o_digit_en   = r_digit_en;
  assign o_frame_tick = r_frame_tick;
  assign o_load_ready = r_load_ready;

endmodule
